// File: rtl/fake_psx_controller.sv
// ============================================================================
// Module   : fake_psx_controller
// Purpose  : Emulated PSX digital pad (responder side of the PSX serial link).
//            Define FAKE_PSX_CTRL_LATCH_EN to snapshot buttons at att fall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fake_psx_controller #(
  parameter int ACK_DELAY = 10,
  parameter int ACK_LEN   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        att,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] buttons,
  output logic        dat,
  output logic        ack,
  output logic        poll_done,
  output logic        cmd_err
);

  localparam int CNT_MAX = (ACK_DELAY > ACK_LEN) ? ACK_DELAY : ACK_LEN;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_XFER      = 3'd1,
    S_ACK_WAIT  = 3'd2,
    S_ACK_PULSE = 3'd3,
    S_IGNORE    = 3'd4
  } state_t;

  state_t             r_state, w_state_n;
  logic               r_att_s1, r_att_s2, r_psx_s1, r_psx_s2, r_psx_d;
  logic               r_cmd_s1, r_cmd_s2;
  logic [2:0]         r_bit_idx, w_bit_idx_n;
  logic [2:0]         r_byte_idx, w_byte_idx_n;
  logic [7:0]         r_tx, w_tx_n, r_rx, w_rx_n, w_rx_shift, w_tx_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic               w_dat_n, w_ack_n, w_poll_done_n, w_cmd_err_n;
  logic               w_fall, w_rise;
  logic [15:0]        w_btn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_att_s1 <= 1'b1;
      r_att_s2 <= 1'b1;
      r_psx_s1 <= 1'b1;
      r_psx_s2 <= 1'b1;
      r_psx_d  <= 1'b1;
      r_cmd_s1 <= 1'b1;
      r_cmd_s2 <= 1'b1;
    end else begin
      r_att_s1 <= att;
      r_att_s2 <= r_att_s1;
      r_psx_s1 <= psx_clk;
      r_psx_s2 <= r_psx_s1;
      r_psx_d  <= r_psx_s2;
      r_cmd_s1 <= cmd;
      r_cmd_s2 <= r_cmd_s1;
    end
  end

  assign w_fall     = r_psx_d & ~r_psx_s2;
  assign w_rise     = ~r_psx_d & r_psx_s2;
  assign w_rx_shift = {r_cmd_s2, r_rx[7:1]};

`ifdef FAKE_PSX_CTRL_LATCH_EN
  // Snapshot taken as the poll starts so bytes 3 and 4 agree with each other.
  logic [15:0] r_btn_snap;
  always_ff @(posedge clk) begin
    if (rst)
      r_btn_snap <= 16'hFFFF;
    else if (r_state == S_IDLE && !r_att_s2)
      r_btn_snap <= buttons;
  end
  assign w_btn = r_btn_snap;
`else
  assign w_btn = buttons;
`endif

  // Byte following the one currently indexed.
  always_comb begin
    case (r_byte_idx)
      3'd0:    w_tx_next = 8'h41;
      3'd1:    w_tx_next = 8'h5A;
      3'd2:    w_tx_next = w_btn[7:0];
      default: w_tx_next = w_btn[15:8];
    endcase
  end

  always_comb begin
    w_state_n     = r_state;
    w_bit_idx_n   = r_bit_idx;
    w_byte_idx_n  = r_byte_idx;
    w_tx_n        = r_tx;
    w_rx_n        = r_rx;
    w_cnt_n       = r_cnt;
    w_dat_n       = dat;
    w_ack_n       = ack;
    w_poll_done_n = 1'b0;
    w_cmd_err_n   = 1'b0;

    if (r_att_s2) begin
      w_state_n    = S_IDLE;
      w_dat_n      = 1'b1;
      w_ack_n      = 1'b1;
      w_bit_idx_n  = 3'd0;
      w_byte_idx_n = 3'd0;
      w_cnt_n      = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_n    = S_XFER;
          w_byte_idx_n = 3'd0;
          w_bit_idx_n  = 3'd0;
          w_tx_n       = 8'hFF;
          w_cnt_n      = '0;
        end
        S_XFER: begin
          if (w_fall)
            w_dat_n = r_tx[r_bit_idx];
          if (w_rise) begin
            w_rx_n      = w_rx_shift;
            w_bit_idx_n = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              if ((r_byte_idx == 3'd0 && w_rx_shift != 8'h01) ||
                  (r_byte_idx == 3'd1 && w_rx_shift != 8'h42)) begin
                w_cmd_err_n = 1'b1;
                w_state_n   = S_IGNORE;
                w_dat_n     = 1'b1;
              end else if (r_byte_idx == 3'd4) begin
                w_poll_done_n = 1'b1;
                w_state_n     = S_IGNORE;
                w_dat_n       = 1'b1;
              end else begin
                w_tx_n       = w_tx_next;
                w_byte_idx_n = r_byte_idx + 3'd1;
                w_bit_idx_n  = 3'd0;
                w_cnt_n      = '0;
                if (ACK_DELAY == 0) begin
                  w_state_n = S_ACK_PULSE;
                  w_ack_n   = 1'b0;
                end else begin
                  w_state_n = S_ACK_WAIT;
                end
              end
            end
          end
        end
        S_ACK_WAIT: begin
          if (w_fall) begin
            w_state_n = S_XFER;
            w_ack_n   = 1'b1;
            w_dat_n   = r_tx[r_bit_idx];
            w_cnt_n   = '0;
          end else if (r_cnt == CNT_W'(ACK_DELAY - 1)) begin
            w_state_n = S_ACK_PULSE;
            w_ack_n   = 1'b0;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_ACK_PULSE: begin
          // An early console edge cuts the pulse short and is served at once.
          if (w_fall) begin
            w_state_n = S_XFER;
            w_ack_n   = 1'b1;
            w_dat_n   = r_tx[r_bit_idx];
            w_cnt_n   = '0;
          end else if (r_cnt == CNT_W'(ACK_LEN - 1)) begin
            w_state_n = S_XFER;
            w_ack_n   = 1'b1;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_IGNORE: begin
          w_dat_n = 1'b1;
          w_ack_n = 1'b1;
        end
        default: begin
          w_state_n = S_IDLE;
          w_dat_n   = 1'b1;
          w_ack_n   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 3'd0;
      r_tx       <= 8'hFF;
      r_rx       <= 8'h00;
      r_cnt      <= '0;
      dat        <= 1'b1;
      ack        <= 1'b1;
      poll_done  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_bit_idx  <= w_bit_idx_n;
      r_byte_idx <= w_byte_idx_n;
      r_tx       <= w_tx_n;
      r_rx       <= w_rx_n;
      r_cnt      <= w_cnt_n;
      dat        <= w_dat_n;
      ack        <= w_ack_n;
      poll_done  <= w_poll_done_n;
      cmd_err    <= w_cmd_err_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fake_psx_controller.sv
// ============================================================================
// Module   : tb_fake_psx_controller
// Purpose  : Scoreboard bench: console-side stimulus, event monitor on pad outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fake_psx_controller;

  localparam int ACK_DELAY = 10;
  localparam int ACK_LEN   = 4;
  localparam int EV_BYTE = 0, EV_ACK = 1, EV_DONE = 2, EV_ERR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        att = 1'b1;
  logic        psx_clk = 1'b1;
  logic        cmd = 1'b1;
  logic [15:0] buttons = 16'hFFFF;
  logic        dat, ack, poll_done, cmd_err;

  typedef struct {int kind; int val;} ev_t;
  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  fake_psx_controller #(.ACK_DELAY(ACK_DELAY), .ACK_LEN(ACK_LEN)) dut (
    .clk(clk), .rst(rst), .att(att), .psx_clk(psx_clk), .cmd(cmd),
    .buttons(buttons), .dat(dat), .ack(ack), .poll_done(poll_done), .cmd_err(cmd_err)
  );

  function automatic string kname(input int k);
    case (k)
      EV_BYTE: return "BYTE";
      EV_ACK:  return "ACKLEN";
      EV_DONE: return "DONE";
      default: return "ERR";
    endcase
  endfunction

  task automatic expect_ev(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic got(input int k, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %s 0x%0h, required no event", kname(k), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL event: got %s 0x%0h, required %s 0x%0h", kname(k), v, kname(e.kind), e.val);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: turns DUT output activity into events for the scoreboard.
  int         mbits = 0;
  logic [7:0] mbyte = 8'h00;
  int         alen = 0;
  logic       psx_prev = 1'b1;
  logic       ack_prev = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (att) begin
        mbits = 0;
      end else if (psx_clk && !psx_prev) begin
        mbyte = {dat, mbyte[7:1]};
        mbits++;
        if (mbits == 8) begin
          got(EV_BYTE, int'(mbyte));
          mbits = 0;
        end
      end
      if (!ack) alen++;
      else if (!ack_prev) begin
        got(EV_ACK, alen);
        alen = 0;
      end
      if (poll_done) got(EV_DONE, 0);
      if (cmd_err) got(EV_ERR, 0);
      psx_prev = psx_clk;
      ack_prev = ack;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer_byte(input logic [7:0] c, input bit already_low);
    for (int i = 0; i < 8; i++) begin
      if (!(i == 0 && already_low)) begin
        psx_clk = 1'b0;
        cmd     = c[i];
      end
      tick(8);
      psx_clk = 1'b1;
      tick(8);
    end
  endtask

  task automatic wait_ack();
    int n = 0;
    while (ack !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    while (ack !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL ack_handshake: got no complete ack pulse in %0d cycles, required one", n);
    end
    tick(4);
  endtask

  task automatic early_drop(input logic b0);
    int n = 0;
    while (ack !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("early_ack_seen", int'(ack), 0);
    psx_clk = 1'b0;
    cmd     = b0;
  endtask

  task automatic att_fall();
    att = 1'b0;
    tick(8);
  endtask

  task automatic att_rise();
    tick(20);
    att = 1'b1;
    tick(20);
  endtask

  task automatic drained(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic full_poll(input logic [15:0] btn, input string name);
    buttons = btn;
    expect_ev(EV_BYTE, 'hFF); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, 'h41); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, 'h5A); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, int'(btn[7:0])); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, int'(btn[15:8])); expect_ev(EV_DONE, 0);
    att_fall();
    xfer_byte(8'h01, 1'b0); wait_ack();
    xfer_byte(8'h42, 1'b0); wait_ack();
    xfer_byte(8'h00, 1'b0); wait_ack();
    xfer_byte(8'h00, 1'b0); wait_ack();
    xfer_byte(8'h00, 1'b0);
    tick(40);
    att_rise();
    drained(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lat;
    tick(5);
    @(negedge clk);
    chk("reset_dat", int'(dat), 1);
    chk("reset_ack", int'(ack), 1);
    chk("reset_poll_done", int'(poll_done), 0);
    chk("reset_cmd_err", int'(cmd_err), 0);
    rst = 1'b0;
    tick(10);

    full_poll(16'hFFFE, "full_poll");

    // Bad address byte: error, then silence until att rises.
    expect_ev(EV_BYTE, 'hFF); expect_ev(EV_ERR, 0); expect_ev(EV_BYTE, 'hFF);
    att_fall();
    xfer_byte(8'h81, 1'b0);
    tick(40);
    chk("bad_addr_dat_idle", int'(dat), 1);
    xfer_byte(8'h42, 1'b0);
    tick(40);
    chk("bad_addr_dat_ignore", int'(dat), 1);
    att_rise();
    drained("bad_addr");
    full_poll(16'h00FF, "poll_after_bad_addr");

    // Bad command byte.
    expect_ev(EV_BYTE, 'hFF); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, 'h41); expect_ev(EV_ERR, 0);
    att_fall();
    xfer_byte(8'h01, 1'b0); wait_ack();
    xfer_byte(8'h43, 1'b0);
    tick(40);
    att_rise();
    drained("bad_cmd");

    // Abort mid byte 2 (0x5A bit 2 is 0, so dat is low before the abort).
    expect_ev(EV_BYTE, 'hFF); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, 'h41); expect_ev(EV_ACK, ACK_LEN);
    att_fall();
    xfer_byte(8'h01, 1'b0); wait_ack();
    xfer_byte(8'h42, 1'b0); wait_ack();
    for (int i = 0; i < 3; i++) begin
      psx_clk = 1'b0; cmd = 1'b0; tick(8);
      psx_clk = 1'b1; tick(8);
    end
    chk("abort_dat_before", int'(dat), 0);
    att = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_dat", int'(dat), 1);
    chk("abort_ack", int'(ack), 1);
    tick(20);
    drained("abort");
    full_poll(16'h1234, "poll_after_abort");

    // Buttons change after the poll has started.
`ifdef FAKE_PSX_CTRL_LATCH_EN
    lat = 8'h00;
`else
    lat = 8'hFF;
`endif
    buttons = 16'h0000;
    expect_ev(EV_BYTE, 'hFF); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, 'h41); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, 'h5A); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, int'(lat)); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, int'(lat)); expect_ev(EV_DONE, 0);
    att_fall();
    xfer_byte(8'h01, 1'b0); wait_ack();
    buttons = 16'hFFFF;
    xfer_byte(8'h42, 1'b0); wait_ack();
    xfer_byte(8'h00, 1'b0); wait_ack();
    xfer_byte(8'h00, 1'b0); wait_ack();
    xfer_byte(8'h00, 1'b0);
    tick(40);
    att_rise();
    drained("latch");

    // Early psx_clk fall two cycles into the ack pulse shortens it to 3 cycles.
    buttons = 16'hA5C3;
    expect_ev(EV_BYTE, 'hFF); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, 'h41); expect_ev(EV_ACK, 3);
    expect_ev(EV_BYTE, 'h5A); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, 'hC3); expect_ev(EV_ACK, ACK_LEN);
    expect_ev(EV_BYTE, 'hA5); expect_ev(EV_DONE, 0);
    att_fall();
    xfer_byte(8'h01, 1'b0); wait_ack();
    xfer_byte(8'h42, 1'b0);
    early_drop(1'b0);
    xfer_byte(8'h00, 1'b1); wait_ack();
    xfer_byte(8'h00, 1'b0); wait_ack();
    xfer_byte(8'h00, 1'b0);
    tick(40);
    att_rise();
    drained("early_edge");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
